// File: rtl/pipeline_job_dispatcher.sv
// Pipeline job dispatcher: accepts one src/dst job at a time, queries the
// schedule agent, validates and commits its decision into the fthread busy
// bitmap, then hands the chosen placement downstream.
module pipeline_job_dispatcher #(
    parameter int NUM_FTHREADS = 4,
    parameter int JOB_ID_W     = 8,
    parameter int RETRY_WAIT   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      job_valid,
    output logic                      job_ready,
    input  logic [JOB_ID_W-1:0]       job_id,
    input  logic                      job_direct,
    input  logic [0:NUM_FTHREADS-1]   job_src_mapping,
    input  logic [0:NUM_FTHREADS-1]   job_dst_mapping,
    output logic                      find_pipeline_schedule,
    output logic                      direct_pipeline_schedule,
    output logic [0:NUM_FTHREADS-1]   src_job_fthread_mapping,
    output logic [0:NUM_FTHREADS-1]   dst_job_fthread_mapping,
    output logic [0:NUM_FTHREADS-1]   fthreads_state,
    input  logic [0:NUM_FTHREADS-1]   src_fthread_select,
    input  logic [0:NUM_FTHREADS-1]   dst_fthread_select,
    input  logic                      dst_fthread_reserve,
    input  logic                      pipeline_schedule_valid,
    input  logic [0:NUM_FTHREADS-1]   fthread_release,
    output logic                      dispatch_valid,
    input  logic                      dispatch_ready,
    output logic [0:NUM_FTHREADS-1]   dispatch_src,
    output logic [0:NUM_FTHREADS-1]   dispatch_dst,
    output logic                      dispatch_dst_reserved,
    output logic [JOB_ID_W-1:0]       dispatch_job_id,
    output logic [15:0]               stat_retries,
    output logic                      err_bad_schedule
);

    localparam int BO_W = $clog2(RETRY_WAIT + 1);

    typedef enum logic [2:0] {
        IDLE,
        QUERY,
        WAIT,
        COMMIT,
        DISPATCH,
        BACKOFF
    } state_t;

    state_t                    state_q, state_d;
    logic [JOB_ID_W-1:0]       job_id_q, job_id_d;
    logic                      direct_q, direct_d;
    logic [0:NUM_FTHREADS-1]   src_map_q, src_map_d;
    logic [0:NUM_FTHREADS-1]   dst_map_q, dst_map_d;
    logic [0:NUM_FTHREADS-1]   busy_q, busy_d;
    logic [0:NUM_FTHREADS-1]   disp_src_q, disp_src_d;
    logic [0:NUM_FTHREADS-1]   disp_dst_q, disp_dst_d;
    logic                      disp_res_q, disp_res_d;
    logic [2:0]                wait_cnt_q, wait_cnt_d;
    logic [BO_W-1:0]           backoff_q, backoff_d;
    logic [15:0]               retries_q, retries_d;
    logic                      err_q, err_d;

    logic [0:NUM_FTHREADS-1]   commit_set;
    logic                      retry_inc;
    logic                      dec_bad;

    // True when at most one bit of the vector is set.
    function automatic logic zero_or_onehot(input logic [0:NUM_FTHREADS-1] v);
        int ones;
        ones = 0;
        for (int i = 0; i < NUM_FTHREADS; i++) begin
            if (v[i]) ones++;
        end
        return (ones <= 1);
    endfunction

    // Decision sanity: legal encodings that stay inside the job's mappings.
    always_comb begin
        dec_bad = !zero_or_onehot(src_fthread_select) ||
                  !zero_or_onehot(dst_fthread_select) ||
                  ((src_fthread_select & ~src_map_q) != '0) ||
                  ((dst_fthread_select & ~dst_map_q) != '0);
    end

    // Next-state and datapath update for the job FSM.
    always_comb begin
        state_d    = state_q;
        job_id_d   = job_id_q;
        direct_d   = direct_q;
        src_map_d  = src_map_q;
        dst_map_d  = dst_map_q;
        disp_src_d = disp_src_q;
        disp_dst_d = disp_dst_q;
        disp_res_d = disp_res_q;
        wait_cnt_d = wait_cnt_q;
        backoff_d  = backoff_q;
        err_d      = err_q;
        commit_set = '0;
        retry_inc  = 1'b0;

        case (state_q)
            IDLE: begin
                if (job_valid) begin
                    job_id_d  = job_id;
                    direct_d  = job_direct;
                    src_map_d = job_src_mapping;
                    dst_map_d = job_dst_mapping;
                    state_d   = QUERY;
                end
            end
            QUERY: begin
                wait_cnt_d = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                if (pipeline_schedule_valid) begin
                    if (dec_bad) err_d = 1'b1;
                    if (dec_bad || (src_fthread_select == '0)) begin
                        retry_inc = 1'b1;
                        backoff_d = BO_W'(RETRY_WAIT);
                        state_d   = BACKOFF;
                    end else begin
                        disp_src_d = src_fthread_select;
                        disp_dst_d = dst_fthread_select;
                        disp_res_d = dst_fthread_reserve && (dst_fthread_select != '0);
                        state_d    = COMMIT;
                    end
                end else if (wait_cnt_q == 3'd7) begin
                    // Agent never answered: ask again, counted as a retry.
                    retry_inc = 1'b1;
                    state_d   = QUERY;
                end else begin
                    wait_cnt_d = wait_cnt_q + 3'd1;
                end
            end
            COMMIT: begin
                // A reserved dst is not free yet, so it is not marked busy here.
                commit_set = disp_src_q | (disp_res_q ? '0 : disp_dst_q);
                state_d    = DISPATCH;
            end
            DISPATCH: begin
                if (dispatch_ready) state_d = IDLE;
            end
            BACKOFF: begin
                if (backoff_q <= BO_W'(1)) state_d = QUERY;
                else backoff_d = backoff_q - BO_W'(1);
            end
            default: state_d = IDLE;
        endcase

        // Set wins over a same-cycle release of the same fthread.
        busy_d = (busy_q & ~fthread_release) | commit_set;

        retries_d = retries_q;
        if (retry_inc && (retries_q != 16'hFFFF)) retries_d = retries_q + 16'd1;
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            job_id_q   <= '0;
            direct_q   <= 1'b0;
            src_map_q  <= '0;
            dst_map_q  <= '0;
            busy_q     <= '0;
            disp_src_q <= '0;
            disp_dst_q <= '0;
            disp_res_q <= 1'b0;
            wait_cnt_q <= '0;
            backoff_q  <= '0;
            retries_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            job_id_q   <= job_id_d;
            direct_q   <= direct_d;
            src_map_q  <= src_map_d;
            dst_map_q  <= dst_map_d;
            busy_q     <= busy_d;
            disp_src_q <= disp_src_d;
            disp_dst_q <= disp_dst_d;
            disp_res_q <= disp_res_d;
            wait_cnt_q <= wait_cnt_d;
            backoff_q  <= backoff_d;
            retries_q  <= retries_d;
            err_q      <= err_d;
        end
    end

    // Output decode; job_ready is masked during reset.
    always_comb begin
        job_ready                = (state_q == IDLE) && !rst;
        find_pipeline_schedule   = (state_q == QUERY);
        dispatch_valid           = (state_q == DISPATCH);
        direct_pipeline_schedule = direct_q;
        src_job_fthread_mapping  = src_map_q;
        dst_job_fthread_mapping  = dst_map_q;
        fthreads_state           = busy_q;
        dispatch_src             = disp_src_q;
        dispatch_dst             = disp_dst_q;
        dispatch_dst_reserved    = disp_res_q;
        dispatch_job_id          = job_id_q;
        stat_retries             = retries_q;
        err_bad_schedule         = err_q;
    end

endmodule

// File: tb/tb_pipeline_job_dispatcher.sv
// Scoreboard bench for pipeline_job_dispatcher with a one-cycle-latency agent model.
module tb_pipeline_job_dispatcher;

    localparam int N  = 4;
    localparam int RW = 4;

    typedef struct packed {
        logic [7:0]   id;
        logic [0:N-1] src;
        logic [0:N-1] dst;
        logic         res;
    } disp_t;

    typedef struct packed {
        logic [0:N-1] src;
        logic [0:N-1] dst;
        logic         res;
    } dec_t;

    logic         clk;
    logic         rst;
    logic         job_valid;
    logic         job_ready;
    logic [7:0]   job_id;
    logic         job_direct;
    logic [0:N-1] job_src_mapping;
    logic [0:N-1] job_dst_mapping;
    logic         find_pipeline_schedule;
    logic         direct_pipeline_schedule;
    logic [0:N-1] src_job_fthread_mapping;
    logic [0:N-1] dst_job_fthread_mapping;
    logic [0:N-1] fthreads_state;
    logic [0:N-1] src_fthread_select;
    logic [0:N-1] dst_fthread_select;
    logic         dst_fthread_reserve;
    logic         pipeline_schedule_valid;
    logic [0:N-1] fthread_release;
    logic         dispatch_valid;
    logic         dispatch_ready;
    logic [0:N-1] dispatch_src;
    logic [0:N-1] dispatch_dst;
    logic         dispatch_dst_reserved;
    logic [7:0]   dispatch_job_id;
    logic [15:0]  stat_retries;
    logic         err_bad_schedule;

    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    int    n_disp = 0;
    disp_t sb[$];
    dec_t  dec_q[$];
    int    find_log[$];
    logic  agent_en   = 1'b1;
    logic  force_resp = 1'b0;

    pipeline_job_dispatcher #(
        .NUM_FTHREADS(N),
        .JOB_ID_W(8),
        .RETRY_WAIT(RW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .job_valid(job_valid),
        .job_ready(job_ready),
        .job_id(job_id),
        .job_direct(job_direct),
        .job_src_mapping(job_src_mapping),
        .job_dst_mapping(job_dst_mapping),
        .find_pipeline_schedule(find_pipeline_schedule),
        .direct_pipeline_schedule(direct_pipeline_schedule),
        .src_job_fthread_mapping(src_job_fthread_mapping),
        .dst_job_fthread_mapping(dst_job_fthread_mapping),
        .fthreads_state(fthreads_state),
        .src_fthread_select(src_fthread_select),
        .dst_fthread_select(dst_fthread_select),
        .dst_fthread_reserve(dst_fthread_reserve),
        .pipeline_schedule_valid(pipeline_schedule_valid),
        .fthread_release(fthread_release),
        .dispatch_valid(dispatch_valid),
        .dispatch_ready(dispatch_ready),
        .dispatch_src(dispatch_src),
        .dispatch_dst(dispatch_dst),
        .dispatch_dst_reserved(dispatch_dst_reserved),
        .dispatch_job_id(dispatch_job_id),
        .stat_retries(stat_retries),
        .err_bad_schedule(err_bad_schedule)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Agent model: answers a query strobe one cycle later with the next scripted decision.
    initial begin
        dec_t d;
        logic fire;
        pipeline_schedule_valid = 1'b0;
        src_fthread_select      = '0;
        dst_fthread_select      = '0;
        dst_fthread_reserve     = 1'b0;
        forever begin
            @(negedge clk);
            fire = (find_pipeline_schedule && agent_en) || force_resp;
            @(posedge clk);
            #1;
            pipeline_schedule_valid = 1'b0;
            src_fthread_select      = '0;
            dst_fthread_select      = '0;
            dst_fthread_reserve     = 1'b0;
            if (fire && dec_q.size() > 0) begin
                d = dec_q.pop_front();
                pipeline_schedule_valid = 1'b1;
                src_fthread_select      = d.src;
                dst_fthread_select      = d.dst;
                dst_fthread_reserve     = d.res;
            end
        end
    end

    // Monitor: pops the scoreboard on every accepted dispatch; logs query strobes.
    initial begin
        disp_t e;
        forever begin
            @(negedge clk);
            if (find_pipeline_schedule) find_log.push_back(cyc);
            if (dispatch_valid && dispatch_ready) begin
                n_disp++;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_dispatch: got id 0x%0h, expected no dispatch", dispatch_job_id);
                end else begin
                    e = sb.pop_front();
                    check("disp_id",  32'(dispatch_job_id), 32'(e.id));
                    check("disp_src", 32'(dispatch_src), 32'(e.src));
                    check("disp_dst", 32'(dispatch_dst), 32'(e.dst));
                    check("disp_res", 32'(dispatch_dst_reserved), 32'(e.res));
                end
            end
        end
    end

    task automatic send_job(input logic [7:0] id, input logic dir,
                            input logic [0:N-1] sm, input logic [0:N-1] dm);
        int n;
        job_id          = id;
        job_direct      = dir;
        job_src_mapping = sm;
        job_dst_mapping = dm;
        job_valid       = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!job_ready && n < 100);
        if (!job_ready) begin
            total++;
            bad++;
            $display("FAIL job_accept: job_ready=0, expected 1 within 100 cycles");
        end
        tick();
        job_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!job_ready && n < 300);
        total++;
        if (!job_ready) begin
            bad++;
            $display("FAIL %s: job_ready=0, expected 1 within 300 cycles", name);
        end
        tick();
    endtask

    initial begin
        int base;
        int n;
        disp_t snap;
        rst             = 1'b1;
        job_valid       = 1'b0;
        job_id          = '0;
        job_direct      = 1'b0;
        job_src_mapping = '0;
        job_dst_mapping = '0;
        fthread_release = '0;
        dispatch_ready  = 1'b1;

        // Reset state
        tick();
        @(negedge clk);
        check("rst_job_ready", 32'(job_ready), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_state",   32'(fthreads_state), 32'd0);
        check("rst_retries", 32'(stat_retries), 32'd0);
        check("rst_err",     32'(err_bad_schedule), 32'd0);
        check("rst_dvalid",  32'(dispatch_valid), 32'd0);
        check("idle_ready",  32'(job_ready), 32'd1);
        tick();

        // Job 1: direct pipeline on an idle bitmap
        dec_q.push_back('{src: 4'b1000, dst: 4'b0100, res: 1'b0});
        sb.push_back('{id: 8'h01, src: 4'b1000, dst: 4'b0100, res: 1'b0});
        send_job(8'h01, 1'b1, 4'b1000, 4'b0100);
        @(negedge clk);
        check("q_find",   32'(find_pipeline_schedule), 32'd1);
        check("q_direct", 32'(direct_pipeline_schedule), 32'd1);
        check("q_srcmap", 32'(src_job_fthread_mapping), 32'(4'b1000));
        check("q_dstmap", 32'(dst_job_fthread_mapping), 32'(4'b0100));
        check("q_ready",  32'(job_ready), 32'd0);
        wait_idle("job1_done");
        check("j1_state", 32'(fthreads_state), 32'(4'b1100));

        // Job 2: reserved dst is not marked busy
        fthread_release = 4'b0100;
        tick();
        fthread_release = '0;
        check("rel_state", 32'(fthreads_state), 32'(4'b1000));
        dec_q.push_back('{src: 4'b0100, dst: 4'b0010, res: 1'b1});
        sb.push_back('{id: 8'h02, src: 4'b0100, dst: 4'b0010, res: 1'b1});
        send_job(8'h02, 1'b0, 4'b1100, 4'b0010);
        wait_idle("job2_done");
        check("j2_state", 32'(fthreads_state), 32'(4'b1100));

        // Job 3: three empty decisions then a src-only placement
        fthread_release = 4'b1111;
        tick();
        fthread_release = '0;
        check("clr_state", 32'(fthreads_state), 32'd0);
        base = find_log.size();
        repeat (3) dec_q.push_back('{src: 4'b0000, dst: 4'b0000, res: 1'b0});
        dec_q.push_back('{src: 4'b0100, dst: 4'b0000, res: 1'b0});
        sb.push_back('{id: 8'h03, src: 4'b0100, dst: 4'b0000, res: 1'b0});
        send_job(8'h03, 1'b0, 4'b0110, 4'b0001);
        wait_idle("job3_done");
        check("j3_retries", 32'(stat_retries), 32'd3);
        check("j3_state",   32'(fthreads_state), 32'(4'b0100));
        check("j3_queries", 32'(find_log.size() - base), 32'd4);
        if (find_log.size() - base >= 4) begin
            for (int i = 0; i < 3; i++)
                check("retry_gap", 32'(find_log[base+i+1] - find_log[base+i]), 32'(RW + 2));
        end

        // Job 4: two-hot src is flagged, backs off, nothing committed
        fthread_release = 4'b1111;
        tick();
        fthread_release = '0;
        dec_q.push_back('{src: 4'b1100, dst: 4'b0000, res: 1'b0});
        dec_q.push_back('{src: 4'b1000, dst: 4'b0000, res: 1'b0});
        sb.push_back('{id: 8'h04, src: 4'b1000, dst: 4'b0000, res: 1'b0});
        send_job(8'h04, 1'b0, 4'b1100, 4'b0000);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!err_bad_schedule && n < 50);
        check("bad_err",     32'(err_bad_schedule), 32'd1);
        check("bad_state",   32'(fthreads_state), 32'd0);
        check("bad_retries", 32'(stat_retries), 32'd4);
        wait_idle("job4_done");
        check("err_sticky", 32'(err_bad_schedule), 32'd1);
        check("j4_state",   32'(fthreads_state), 32'(4'b1000));

        // Job 5: release collides with commit; dispatch stalled by ready low
        fthread_release = 4'b1111;
        tick();
        fthread_release = '0;
        dispatch_ready  = 1'b0;
        dec_q.push_back('{src: 4'b1000, dst: 4'b0000, res: 1'b0});
        sb.push_back('{id: 8'h05, src: 4'b1000, dst: 4'b0000, res: 1'b0});
        send_job(8'h05, 1'b1, 4'b1000, 4'b0001);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pipeline_schedule_valid && n < 20);
        check("j5_decision", 32'(pipeline_schedule_valid), 32'd1);
        tick();
        fthread_release = 4'b1000;
        tick();
        fthread_release = '0;
        @(negedge clk);
        check("setwins_state", 32'(fthreads_state), 32'(4'b1000));
        check("stall_valid",   32'(dispatch_valid), 32'd1);
        snap = '{id: dispatch_job_id, src: dispatch_src, dst: dispatch_dst, res: dispatch_dst_reserved};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_fields", 32'({dispatch_valid, dispatch_job_id, dispatch_src, dispatch_dst, dispatch_dst_reserved}),
                  32'({1'b1, snap.id, snap.src, snap.dst, snap.res}));
            check("stall_ready", 32'(job_ready), 32'd0);
        end
        tick();
        dispatch_ready = 1'b1;
        wait_idle("job5_done");

        // Job 6: reset while waiting for the decision; late decision ignored
        agent_en = 1'b0;
        send_job(8'h06, 1'b1, 4'b0100, 4'b0000);
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("wrst_state",   32'(fthreads_state), 32'd0);
        check("wrst_ready",   32'(job_ready), 32'd0);
        check("wrst_find",    32'(find_pipeline_schedule), 32'd0);
        check("wrst_srcmap",  32'(src_job_fthread_mapping), 32'd0);
        check("wrst_retries", 32'(stat_retries), 32'd0);
        check("wrst_err",     32'(err_bad_schedule), 32'd0);
        check("wrst_dvalid",  32'(dispatch_valid), 32'd0);
        tick();
        rst = 1'b0;
        dec_q.push_back('{src: 4'b0100, dst: 4'b0000, res: 1'b0});
        force_resp = 1'b1;
        tick();
        force_resp = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        check("late_state",  32'(fthreads_state), 32'd0);
        check("late_dvalid", 32'(dispatch_valid), 32'd0);
        check("late_ready",  32'(job_ready), 32'd1);
        check("late_find",   32'(find_pipeline_schedule), 32'd0);

        check("sb_empty",  32'(sb.size()), 32'd0);
        check("disp_count", 32'(n_disp), 32'd5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, expected to finish earlier");
        $fatal(1, "watchdog");
    end

endmodule
